// File: rtl/vga_fb_arbiter_if.sv
// Request, RAM and line-buffer signals of the frame-buffer arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface vga_fb_arbiter_if #(
  parameter int AW  = 17,
  parameter int DW  = 8,
  parameter int LBW = 10
);
  logic           rd_req;
  logic [AW-1:0]  rd_base;
  logic           wr_req;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_ack;
  logic           mem_en;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           lb_we;
  logic [LBW-1:0] lb_addr;
  logic [DW-1:0]  lb_data;
  logic           fetch_busy;
  logic           fetch_done;
  logic           overrun;

  modport slave (
    input  rd_req, rd_base, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
    output lb_we, lb_addr, lb_data, fetch_busy, fetch_done, overrun
  );

  modport master (
    output rd_req, rd_base, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
    input  lb_we, lb_addr, lb_data, fetch_busy, fetch_done, overrun
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display line fetch has priority, scanner
// pixel writes get a guaranteed slot every GAP reads inside a burst.
module vga_fb_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 8,
  parameter int LINE_WORDS = 640,
  parameter int LBW        = 10,
  parameter int GAP        = 8
) (
  input  logic clk,
  input  logic clr,
  vga_fb_arbiter_if.slave bus
);

  localparam int SW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [SW-1:0]  GAP_C    = SW'(GAP);
  localparam logic [LBW-1:0] LAST_IDX = LBW'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t         state_q, state_d;
  logic           pend_q, pend_d;
  logic [AW-1:0]  pend_base_q, pend_base_d;
  logic [AW-1:0]  base_q, base_d;
  logic [LBW-1:0] idx_q, idx_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [LBW-1:0] rd_idx_q, rd_idx_d;
  logic           wr_ack_q, wr_ack_d;
  logic           mem_en_q, mem_en_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           lb_we_q, lb_we_d;
  logic [LBW-1:0] lb_addr_q, lb_addr_d;
  logic           fetch_done_q, fetch_done_d;
  logic           fetch_busy_q, fetch_busy_d;
  logic           overrun_q, overrun_d;

  logic           start, active, wr_ok, do_wr;
  logic [AW-1:0]  cur_base;
  logic [LBW-1:0] cur_idx;
  logic [SW-1:0]  cur_slot;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_base_d  = pend_base_q;
    base_d       = base_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    rd_idx_d     = rd_idx_q;
    overrun_d    = overrun_q;
    wr_ack_d     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    start        = 1'b0;
    do_wr        = 1'b0;
    cur_base     = base_q;
    cur_idx      = idx_q;
    cur_slot     = slot_q;
    wr_ok        = bus.wr_req & ~wr_ack_q;

    // Read data returns one cycle after the read, so the line-buffer side
    // simply trails whatever read was on the RAM port last cycle.
    lb_we_d      = mem_en_q & ~mem_we_q;
    lb_addr_d    = lb_we_d ? rd_idx_q : lb_addr_q;
    fetch_done_d = lb_we_d && (rd_idx_q == LAST_IDX);

    unique case (state_q)
      IDLE: begin
        if (bus.rd_req || pend_q) begin
          start    = 1'b1;
          cur_base = pend_q ? pend_base_q : bus.rd_base;
          cur_idx  = '0;
          cur_slot = '0;
          if (pend_q && bus.rd_req) begin
            pend_d      = 1'b1;
            pend_base_d = bus.rd_base;
          end else begin
            pend_d = 1'b0;
          end
        end else if (wr_ok) begin
          do_wr = 1'b1;
        end
      end
      FETCH: begin
        if (bus.rd_req) begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_base_d = bus.rd_base;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The burst start cycle already issues read 0, giving one-cycle latency.
    active = start || (state_q == FETCH);
    if (active) begin
      state_d = FETCH;
      base_d  = cur_base;
      if ((GAP != 0) && (cur_slot == GAP_C) && wr_ok) begin
        do_wr  = 1'b1;
        slot_d = '0;
        idx_d  = cur_idx;
      end else begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = cur_base + AW'(cur_idx);
        rd_idx_d   = cur_idx;
        idx_d      = cur_idx + 1'b1;
        slot_d     = (cur_slot == GAP_C) ? cur_slot : cur_slot + 1'b1;
        if (cur_idx == LAST_IDX) begin
          state_d = IDLE;
        end
      end
    end

    if (do_wr) begin
      wr_ack_d    = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = bus.wr_addr;
      mem_wdata_d = bus.wr_data;
    end

    fetch_busy_d = (state_d == FETCH) || pend_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_base_q  <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      slot_q       <= '0;
      rd_idx_q     <= '0;
      wr_ack_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      fetch_done_q <= 1'b0;
      fetch_busy_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_base_q  <= pend_base_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      rd_idx_q     <= rd_idx_d;
      wr_ack_q     <= wr_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      lb_we_q      <= lb_we_d;
      lb_addr_q    <= lb_addr_d;
      fetch_done_q <= fetch_done_d;
      fetch_busy_q <= fetch_busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.wr_ack     = wr_ack_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.lb_we      = lb_we_q;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_data    = bus.mem_rdata;
  assign bus.fetch_busy = fetch_busy_q;
  assign bus.fetch_done = fetch_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed stimulus queues expected RAM
// and line-buffer events with their cycle numbers; a monitor pops and compares.
module tb_vga_fb_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 8;
  localparam int LW  = 640;
  localparam int LBW = 10;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW), .LBW(LBW)) bus ();

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .LINE_WORDS(LW), .LBW(LBW), .GAP(GAP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h3C;
  endfunction

  // RAM model: read data valid one cycle after the read.
  always @(posedge clk)
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) bus.mem_rdata <= fdata(bus.mem_addr);

  typedef struct {
    int unsigned   cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct {
    int unsigned    cyc;
    logic [LBW-1:0] idx;
    logic [DW-1:0]  data;
    logic           done;
  } lb_exp_t;

  mem_exp_t mq[$];
  lb_exp_t  lq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outvec();
    return 64'({bus.mem_en, bus.mem_we, bus.wr_ack, bus.lb_we, bus.fetch_done,
                bus.fetch_busy, bus.overrun, bus.mem_addr, bus.mem_wdata, bus.lb_addr});
  endfunction

  // n0 is the cycle rd_req is presented; reads start at n0+1.
  task automatic push_burst(input logic [AW-1:0] base, input int unsigned n0,
                            input int nrd, input int nlb, input int wr_after,
                            input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    int unsigned c;
    c = n0 + 1;
    for (int i = 0; i < nrd; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      mq.push_back('{c, 1'b0, a, DW'(0)});
      if (i < nlb) lq.push_back('{c + 1, LBW'(i), fdata(a), (i == LW - 1)});
      c++;
      if (i == wr_after) begin
        mq.push_back('{c, 1'b1, waddr, wdata});
        c++;
      end
    end
  endtask

  task automatic monitor();
    mem_exp_t me;
    lb_exp_t  le;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        if (mq.size() == 0) begin
          chk("mem_op_unexpected", 64'(bus.mem_en), 64'(0));
        end else begin
          me = mq.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(me.cyc));
          chk("mem_we", 64'(bus.mem_we), 64'(me.we));
          chk("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
          if (me.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(me.data));
        end
      end
      if (bus.lb_we === 1'b1) begin
        if (lq.size() == 0) begin
          chk("lb_we_unexpected", 64'(bus.lb_we), 64'(0));
        end else begin
          le = lq.pop_front();
          chk("lb_cycle", 64'(cyc), 64'(le.cyc));
          chk("lb_addr", 64'(bus.lb_addr), 64'(le.idx));
          chk("lb_data", 64'(bus.lb_data), 64'(le.data));
          chk("fetch_done", 64'(bus.fetch_done), 64'(le.done));
        end
      end else if (bus.fetch_done !== 1'b0) begin
        chk("fetch_done_stray", 64'(bus.fetch_done), 64'(0));
      end
      if (bus.wr_ack === 1'b1 || (bus.mem_en === 1'b1 && bus.mem_we === 1'b1))
        chk("wr_ack", 64'(bus.wr_ack), 64'(bus.mem_en & bus.mem_we));
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned t);
    while (cyc < t) sync();
  endtask

  task automatic rd_pulse(input logic [AW-1:0] b);
    bus.rd_req  = 1'b1;
    bus.rd_base = b;
    sync();
    bus.rd_req  = 1'b0;
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (bus.wr_ack === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("wr_ack_timeout", 64'(bus.wr_ack), 64'(1));
    sync();
    bus.wr_req = 1'b0;
  endtask

  task automatic drain(input string name);
    chk({name, "_mem_left"}, 64'(mq.size()), 64'(0));
    chk({name, "_lb_left"}, 64'(lq.size()), 64'(0));
  endtask

  int unsigned n;

  initial begin
    bus.rd_req  = 1'b0;
    bus.rd_base = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    #3 chk("reset_outputs", outvec(), 64'(0));

    // 1: plain line fetch
    sync();
    n = cyc;
    push_burst(17'h00100, n, LW, LW, -1, '0, '0);
    rd_pulse(17'h00100);
    goto(n + 320); #3 chk("t1_busy_mid", 64'(bus.fetch_busy), 64'(1));
    goto(n + 641); #3 chk("t1_busy_end", 64'(bus.fetch_busy), 64'(0));
    goto(n + 650);
    drain("t1");

    // 2: single write while idle, wr_req still high in the ack cycle
    sync();
    n = cyc;
    mq.push_back('{n + 1, 1'b1, 17'h1ABCD, 8'h5A});
    wr_txn(17'h1ABCD, 8'h5A);
    goto(n + 10);
    drain("t2");

    // 3: write raised mid-burst takes the slot after read 7
    sync();
    n = cyc;
    push_burst(17'h00800, n, LW, LW, 7, 17'h00042, 8'hC3);
    rd_pulse(17'h00800);
    goto(n + 3);
    wr_txn(17'h00042, 8'hC3);
    goto(n + 641); #3 chk("t3_busy_last", 64'(bus.fetch_busy), 64'(0));
    goto(n + 650);
    drain("t3");

    // 4: simultaneous rd_req/wr_req, burst wraps the address space
    sync();
    n = cyc;
    push_burst(17'h1FF00, n, LW, LW, 7, 17'h12345, 8'h99);
    fork
      rd_pulse(17'h1FF00);
      wr_txn(17'h12345, 8'h99);
    join
    goto(n + 650);
    drain("t4");

    // 5: pending request chains, third request overruns
    sync();
    n = cyc;
    push_burst(17'h00100, n, LW, LW, -1, '0, '0);
    push_burst(17'h00400, n + 640, LW, LW, -1, '0, '0);
    rd_pulse(17'h00100);
    goto(n + 100);
    rd_pulse(17'h00400);
    goto(n + 150); #3 chk("t5_no_overrun_yet", 64'(bus.overrun), 64'(0));
    goto(n + 200);
    rd_pulse(17'h00600);
    goto(n + 202); #3 chk("t5_overrun_set", 64'(bus.overrun), 64'(1));
    goto(n + 640); #3 chk("t5_busy_between", 64'(bus.fetch_busy), 64'(1));
    goto(n + 1290);
    drain("t5");
    chk("t5_overrun_sticky", 64'(bus.overrun), 64'(1));

    // 6: clr at idx 300 abandons the burst and clears overrun
    sync();
    n = cyc;
    push_burst(17'h00200, n, 301, 300, -1, '0, '0);
    rd_pulse(17'h00200);
    goto(n + 301);
    clr = 1'b1;
    goto(n + 302);
    clr = 1'b0;
    #3 chk("t6_clr_outputs", outvec(), 64'(0));
    goto(n + 310);
    drain("t6a");
    sync();
    n = cyc;
    push_burst(17'h00200, n, LW, LW, -1, '0, '0);
    rd_pulse(17'h00200);
    goto(n + 650);
    drain("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters:
  - the VGA display path, which fetches one scan line into a line buffer per request;
  - the scanner write path, which writes single pixels.
- The display fetch has priority. During a burst, the scanner gets one guaranteed write slot every GAP reads, so it cannot starve.
- Sits between the horizontal/vertical timing counters, the scanner capture logic and the frame-buffer RAM. The line fetch is started during horizontal blanking.

Parameters:
- AW, 17, frame-buffer address width.
- DW, 8, pixel data width.
- LINE_WORDS, 640, words per line burst (1..2^LBW).
- LBW, 10, line-buffer address width.
- GAP, 8, reads between write slots inside a burst (0 = no interleave).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- rd_req  in  1  one-cycle pulse: fetch one line.
- rd_base  in  AW  line start address, sampled with rd_req.
- wr_req  in  1  level; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ack  out  1  one-cycle pulse: write issued to RAM.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after a read.
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  LBW  line-buffer address (word index within line).
- lb_data  out  DW  line-buffer data.
- fetch_busy  out  1  burst in progress or pending.
- fetch_done  out  1  one-cycle pulse with last lb_we of a burst.
- overrun  out  1  sticky: rd_req lost.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous and active-high.
- Registered outputs: all outputs except lb_data are registered. lb_data = mem_rdata passthrough.
- Reset values:
  - all strobes, mem_* outputs, lb_addr, overrun and fetch_busy are 0;
  - FSM goes to IDLE;
  - pending request, base latch, word index and slot counter are cleared.
- Reset mid-burst: the burst is abandoned. No further lb_we and no fetch_done are produced.
- FSM states: IDLE, FETCH.
- IDLE:
  - If rd_req or pending is set → FETCH. Load base; idx=0; slot_cnt=0; clear pending.
  - Otherwise, if wr_req=1 and wr_ack=0 → issue a write next cycle: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Otherwise mem_en=0.
  - rd_req and wr_req in the same cycle: the fetch wins and the write waits.
- FETCH, per cycle:
  - Write slot: if GAP≠0, slot_cnt==GAP, wr_req=1 and wr_ack=0 → issue the write, as in IDLE. Then slot_cnt=0 and idx is unchanged.
  - Read: otherwise issue a read: mem_en=1, mem_we=0, mem_addr=base+idx (mod 2^AW). Then idx+1, and slot_cnt increments, saturating at GAP.
  - End of burst: after the read with idx==LINE_WORDS-1 is issued → IDLE. A pending request starts the next burst immediately with no idle cycle.
- Read pipeline:
  - lb_we=1 and lb_addr=idx of the read, one cycle after each read cycle.
  - fetch_done=1 with the lb_we for idx LINE_WORDS-1.
  - Burst latency: rd_req to first read on mem is 1 cycle. First lb_we is 2 cycles after rd_req.
  - Total burst length = LINE_WORDS + number of write slots.
- Write handshake:
  - wr_req is ignored in any cycle where wr_ack=1, so one request produces exactly one write.
  - Maximum write rate is one write every 2 cycles.
- rd_req during FETCH: it is stored as pending (1 deep) and its rd_base is latched.
  - rd_req while pending is already set: it is dropped, overrun is set to 1, and the latched base is not overwritten.
  - overrun clears only on clr.
- fetch_busy = (state==FETCH) | pending. It falls in the cycle after the last read is issued.
- Address wrap: base+idx wraps modulo 2^AW. lb_addr never exceeds LINE_WORDS-1.

Test Plan:
1. Reset, then rd_req with rd_base=0x00100 and no writes:
   - 640 reads at addresses 0x00100..0x0037F on consecutive cycles;
   - lb_we for lb_addr 0..639, each one cycle after its read;
   - fetch_done coincident with lb_addr=639;
   - fetch_busy low 641 cycles after rd_req.
2. wr_req held with addr=0x1ABCD, data=0x5A, while IDLE:
   - exactly one cycle with mem_we=1, addr 0x1ABCD, data 0x5A, and wr_ack=1;
   - no second write while wr_req is still high in the ack cycle.
3. wr_req asserted during a burst, GAP=8:
   - the write is issued after read idx 7, and the next read is idx 8;
   - burst length is 641 cycles;
   - lb_addr sequence has no gaps or duplicates.
4. rd_req and wr_req in the same IDLE cycle:
   - read burst starts first;
   - write issued at the first slot (after 8 reads).
5. Second rd_req (base 0x00400) mid-burst, then a third rd_req:
   - second burst begins the cycle after the first burst's last read;
   - third request is dropped and overrun=1 until clr.
6. clr asserted at idx 300:
   - next cycle all outputs are 0, with no lb_we and no fetch_done;
   - a new rd_req then starts again from idx 0.
